feature_weight_buffer: RTL and testbench
========================================

Name: feature_weight_buffer

Overview:
- Double-buffered (ping-pong) convolution weight store; successor to the single-bank feature weight memory.
- Loads multi-bit weights one per beat over a valid/ready stream into the shadow bank while the PE array reads the active bank.
- A consumer-issued swap makes the newly loaded set active atomically, so weights change between image tiles without stalling the MACs.

Parameters:
- KERNEL_SIZE, 3, kernel edge; TAPS = KERNEL_SIZE*KERNEL_SIZE weights per feature.
- NUM_FEATURES, 10, number of feature maps (PE channels).
- WEIGHT_W, 8, bits per weight, two's complement; 1 gives binary weights.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  begin loading a full weight set into the shadow bank.
- wt_valid  in  1  wt_data valid this cycle.
- wt_data  in  WEIGHT_W  next weight in load order.
- wt_ready  out  1  buffer accepts a beat; a beat transfers when wt_valid && wt_ready.
- load_busy  out  1  high in LOAD state.
- load_done  out  1  one-cycle pulse after the final beat is written.
- swap  in  1  request to make the shadow bank active.
- active_bank  out  1  index of the bank driving weights_output.
- active_valid  out  1  active bank holds a complete loaded set.
- weights_output  out  NUM_FEATURES*TAPS*WEIGHT_W  flattened active bank; weight (f,t) at bits [(f*TAPS+t)*WEIGHT_W +: WEIGHT_W].

Behaviour:
- Reset (rst high at posedge) clears:
  - Both banks to 0.
  - State to IDLE, tap/feature counters to 0.
  - active_bank=0, active_valid=0, load_done=0.
  - wt_ready=0 and load_busy=0, since both derive from state.
  - Reset mid-load discards partial data; no load_done.
- States: IDLE, LOAD, FULL.
  - IDLE: load_start -> LOAD with counters cleared.
  - LOAD: wt_ready=1 (combinational from state). On each transfer:
    - Write shadow[f][t] = wt_data, where shadow = ~active_bank.
    - t increments; at t=TAPS-1, t wraps to 0 and f increments.
    - The transfer at f=NUM_FEATURES-1, t=TAPS-1 -> FULL, and load_done pulses the following cycle.
  - FULL: swap -> active_bank toggles, active_valid=1, state -> IDLE; weights_output reflects the new bank from the same edge.
  - FULL: load_start without swap -> LOAD, restarting and overwriting the shadow bank from (0,0).
- Load order: feature-major, tap-minor. Tap index t = row*KERNEL_SIZE + col, row-major.
- wt_valid low in LOAD: counters hold, no write; gaps of any length are allowed.
- load_start while in LOAD: ignored.
- swap outside FULL, including the cycle of the final beat: ignored, no state change.
- swap and load_start together in FULL: swap wins, state -> IDLE; load_start is dropped.
- weights_output is a pure mux of the active bank, with no read latency. The active bank is never written.
- Counter widths: $clog2(TAPS) and $clog2(NUM_FEATURES), each at least 1 bit. Counters never exceed their terminal values.

Decomposition:
- Shared package cnn_pkg holds:
  - TAPS as a function of KERNEL_SIZE.
  - The state enum typedef wbuf_state_t {IDLE, LOAD, FULL}.
  - The index helper for the flattened slice offset.
- One natural sub-module: weight_bank, a single NUM_FEATURES x TAPS x WEIGHT_W register array with write enable, address (f,t), data in, and full flattened read out. Instantiate it twice.
- The controller (FSM, counters, bank select) stays in feature_weight_buffer.

Test Plan:
- Reset, then idle -> weights_output all 0; active_valid=0, active_bank=0, wt_ready=0.
- load_start, then stream 90 beats wt_data = index (0..89, WEIGHT_W=8) -> load_done pulses exactly once, one cycle after beat 89. Then swap -> next cycle active_bank=1, active_valid=1, weight(f=2,t=4)=22.
- Second load (data = 100+index) with random wt_valid gaps -> during the whole load, weights_output still shows the first set. After swap: active_bank=0, weight(9,8)=189.
- swap pulsed in IDLE, mid-LOAD, and on the final-beat cycle -> active_bank unchanged; a later swap in FULL succeeds.
- rst asserted after 40 beats -> next cycle state IDLE; both banks zero; no load_done; active_valid=0.
- In FULL, load_start without swap, then reload with data = 7 -> all active shadow weights 7 after swap; the earlier unswapped data is never visible.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution weight store.
// Holds the tap count, controller states and flattened-slice indexing.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } wbuf_state_t;

    function automatic int taps_of(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_ofs(
        input int f,
        input int t,
        input int taps,
        input int w
    );
        return (f * taps + t) * w;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One NUM_FEATURES x TAPS register bank of signed weights.
// Single write port addressed by (feature, tap); whole bank read flat.
module weight_bank
    import cnn_pkg::*;
#(
    parameter int NUM_FEATURES = 10,
    parameter int TAPS         = 9,
    parameter int WEIGHT_W     = 8,
    parameter int FW           = cnt_w(NUM_FEATURES),
    parameter int TW           = cnt_w(TAPS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we_i,
    input  logic [FW-1:0]                       f_i,
    input  logic [TW-1:0]                       t_i,
    input  logic [WEIGHT_W-1:0]                 d_i,
    output logic [NUM_FEATURES*TAPS*WEIGHT_W-1:0] q_o
);

    localparam int BITS = NUM_FEATURES * TAPS * WEIGHT_W;

    logic [BITS-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[slice_ofs(int'(f_i), int'(t_i), TAPS, WEIGHT_W) +: WEIGHT_W] <= d_i;
        end
    end

    assign q_o = mem_q;

endmodule

// File: rtl/feature_weight_buffer.sv
// Ping-pong weight store: loads stream into the shadow bank while
// the PE array reads the active bank; swap flips banks atomically.
module feature_weight_buffer
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_FEATURES = 10,
    parameter int WEIGHT_W     = 8,
    parameter int TAPS         = taps_of(KERNEL_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load_start,
    input  logic                                  wt_valid,
    input  logic [WEIGHT_W-1:0]                   wt_data,
    output logic                                  wt_ready,
    output logic                                  load_busy,
    output logic                                  load_done,
    input  logic                                  swap,
    output logic                                  active_bank,
    output logic                                  active_valid,
    output logic [NUM_FEATURES*TAPS*WEIGHT_W-1:0] weights_output
);

    localparam int FW   = cnt_w(NUM_FEATURES);
    localparam int TW   = cnt_w(TAPS);
    localparam int BITS = NUM_FEATURES * TAPS * WEIGHT_W;

    localparam logic [TW-1:0] T_LAST = TW'(TAPS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FEATURES - 1);

    wbuf_state_t   state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [FW-1:0] f_q, f_d;
    logic          bank_q, bank_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          we;
    logic [BITS-1:0] q0, q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            f_q     <= '0;
            bank_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            f_q     <= f_d;
            bank_q  <= bank_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        f_d      = f_q;
        bank_d   = bank_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        we       = 1'b0;
        wt_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    t_d     = '0;
                    f_d     = '0;
                end
            end
            LOAD: begin
                wt_ready = 1'b1;
                if (wt_valid) begin
                    we = 1'b1;
                    if (t_q == T_LAST) begin
                        t_d = '0;
                        if (f_q == F_LAST) begin
                            state_d = FULL;
                            done_d  = 1'b1;
                        end else begin
                            f_d = f_q + 1'b1;
                        end
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            FULL: begin
                // swap has priority over a concurrent reload request
                if (swap) begin
                    bank_d  = ~bank_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (load_start) begin
                    state_d = LOAD;
                    t_d     = '0;
                    f_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    weight_bank #(
        .NUM_FEATURES(NUM_FEATURES),
        .TAPS        (TAPS),
        .WEIGHT_W    (WEIGHT_W)
    ) u_bank0 (
        .clk (clk),
        .rst (rst),
        .we_i(we & bank_q),
        .f_i (f_q),
        .t_i (t_q),
        .d_i (wt_data),
        .q_o (q0)
    );

    weight_bank #(
        .NUM_FEATURES(NUM_FEATURES),
        .TAPS        (TAPS),
        .WEIGHT_W    (WEIGHT_W)
    ) u_bank1 (
        .clk (clk),
        .rst (rst),
        .we_i(we & ~bank_q),
        .f_i (f_q),
        .t_i (t_q),
        .d_i (wt_data),
        .q_o (q1)
    );

    assign load_busy      = (state_q == LOAD);
    assign load_done      = done_q;
    assign active_bank    = bank_q;
    assign active_valid   = valid_q;
    assign weights_output = bank_q ? q1 : q0;

endmodule

// File: tb/tb_feature_weight_buffer.sv
// Self-checking bench for feature_weight_buffer.
// Compares the DUT against an index-based model of the two weight sets.
module tb_feature_weight_buffer;

    localparam int KS = 3;
    localparam int NF = 10;
    localparam int W  = 8;
    localparam int T  = KS * KS;
    localparam int N  = NF * T;
    localparam int OW = N * W;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          wt_valid;
    logic [W-1:0]  wt_data;
    logic          wt_ready;
    logic          load_busy;
    logic          load_done;
    logic          swap;
    logic          active_bank;
    logic          active_valid;
    logic [OW-1:0] weights_output;

    feature_weight_buffer #(
        .KERNEL_SIZE (KS),
        .NUM_FEATURES(NF),
        .WEIGHT_W    (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .wt_valid      (wt_valid),
        .wt_data       (wt_data),
        .wt_ready      (wt_ready),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .swap          (swap),
        .active_bank   (active_bank),
        .active_valid  (active_valid),
        .weights_output(weights_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // model: two weight sets indexed by load order, plus a load phase
    logic [W-1:0] mb[2][N];
    int  m_mode;
    int  m_idx;
    bit  m_act;
    bit  m_vld;
    bit  m_done;

    typedef struct {
        bit ls;
        bit sw;
        bit e_ready;
        bit e_busy;
        bit e_bank;
        bit e_valid;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [OW-1:0] got,
                        input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] mvec();
        logic [OW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = mb[m_act][k];
        return v;
    endfunction

    function automatic logic [W-1:0] wt(input int f, input int t);
        return weights_output[(f*T + t)*W +: W];
    endfunction

    task automatic model_step(input bit r, input bit ls, input bit sw,
                              input bit v, input logic [W-1:0] d);
        if (r) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < N; k++) mb[b][k] = '0;
            m_mode = 0;
            m_idx  = 0;
            m_act  = 0;
            m_vld  = 0;
            m_done = 0;
            return;
        end
        m_done = 0;
        if (m_mode == 0) begin
            if (ls) begin
                m_mode = 1;
                m_idx  = 0;
            end
        end else if (m_mode == 1) begin
            if (v) begin
                mb[!m_act][m_idx] = d;
                if (m_idx == N - 1) begin
                    m_mode = 2;
                    m_done = 1;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (sw) begin
                m_act  = !m_act;
                m_vld  = 1;
                m_mode = 0;
            end else if (ls) begin
                m_mode = 1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit ls, input bit sw,
                        input bit v, input logic [W-1:0] d);
        rst        = r;
        load_start = ls;
        swap       = sw;
        wt_valid   = v;
        wt_data    = d;
        @(posedge clk);
        model_step(r, ls, sw, v, d);
        @(negedge clk);
        if (load_done === 1'b1) done_cnt++;
        chk("wt_ready", 32'(wt_ready), 32'(m_mode == 1));
        chk("load_busy", 32'(load_busy), 32'(m_mode == 1));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("active_bank", 32'(active_bank), 32'(m_act));
        chk("active_valid", 32'(active_valid), 32'(m_vld));
        chkv("weights_output", weights_output, mvec());
    endtask

    task automatic stream(input int base, input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 1, W'(base + i));
    endtask

    initial begin
        logic [OW-1:0] all7;
        int dc0;
        for (int k = 0; k < N; k++) all7[k*W +: W] = 8'h07;

        tbl[0] = '{ls:0, sw:0, e_ready:0, e_busy:0, e_bank:0, e_valid:0};
        tbl[1] = '{ls:0, sw:1, e_ready:0, e_busy:0, e_bank:0, e_valid:0};
        tbl[2] = '{ls:1, sw:0, e_ready:1, e_busy:1, e_bank:0, e_valid:0};
        tbl[3] = '{ls:1, sw:0, e_ready:1, e_busy:1, e_bank:0, e_valid:0};
        tbl[4] = '{ls:0, sw:1, e_ready:1, e_busy:1, e_bank:0, e_valid:0};
        tbl[5] = '{ls:0, sw:0, e_ready:1, e_busy:1, e_bank:0, e_valid:0};

        rst = 1; load_start = 0; swap = 0; wt_valid = 0; wt_data = '0;
        @(negedge clk);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chkv("reset_zero", weights_output, '0);

        for (int i = 0; i < 6; i++) begin
            tick(0, tbl[i].ls, tbl[i].sw, 0, 0);
            chk($sformatf("tbl%0d_ready", i), 32'(wt_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_busy", i), 32'(load_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_bank", i), 32'(active_bank), 32'(tbl[i].e_bank));
            chk($sformatf("tbl%0d_valid", i), 32'(active_valid), 32'(tbl[i].e_valid));
        end

        // first set: index data, swap asserted on the final beat
        done_cnt = 0;
        for (int i = 0; i < N; i++) tick(0, 0, i == N - 1, 1, W'(i));
        chk("done_after_last", 32'(load_done), 32'd1);
        chk("bank_after_lastswap", 32'(active_bank), 32'd0);
        tick(0, 0, 0, 0, 0);
        chk("done_once", 32'(done_cnt), 32'd1);
        tick(0, 0, 1, 0, 0);
        chk("swap1_bank", 32'(active_bank), 32'd1);
        chk("swap1_valid", 32'(active_valid), 32'd1);
        chk("w_2_4", 32'(wt(2, 4)), 32'd22);

        // second set with random gaps; active view must stay on set one
        tick(0, 1, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                tick(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     0, W'($urandom));
            tick(0, 0, 0, 1, W'(100 + i));
            chk("hold_w_2_4", 32'(wt(2, 4)), 32'd22);
        end
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("swap2_bank", 32'(active_bank), 32'd0);
        chk("w_9_8", 32'(wt(9, 8)), 32'd189);

        // reset in the middle of a load
        tick(0, 1, 0, 0, 0);
        stream(50, 40);
        dc0 = done_cnt;
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_valid", 32'(active_valid), 32'd0);
        chk("rst_bank", 32'(active_bank), 32'd0);
        chk("rst_nodone", 32'(done_cnt), 32'(dc0));
        chkv("rst_zero", weights_output, '0);

        // reload from FULL without swapping; stale set never shown
        tick(0, 1, 0, 0, 0);
        stream(0, N);
        tick(0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0);
        stream(150, N);
        tick(0, 1, 0, 0, 0);
        chk("reload_busy", 32'(load_busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            tick(0, 0, 0, 1, 8'h07);
            chk("reload_hold", 32'(wt(1, 0)), 32'd9);
        end
        tick(0, 0, 1, 0, 0);
        chk("reload_bank", 32'(active_bank), 32'd0);
        chkv("reload_all7", weights_output, all7);

        // swap and load_start together in FULL: swap wins
        tick(0, 1, 0, 0, 0);
        stream(30, N);
        tick(0, 1, 1, 0, 0);
        chk("both_busy", 32'(load_busy), 32'd0);
        chk("both_bank", 32'(active_bank), 32'd1);
        chk("both_w_0_3", 32'(wt(0, 3)), 32'd33);

        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                 W'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
